// File: rtl/quotient_normalizer_pkg.sv
// Shared types and default widths for the divider quotient normalizer.
// The FSM state encoding is exported so the top module and any wrapper agree on it.
package qnorm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } qnorm_state_t;

  localparam int C_NUM_BITS_DEF = 24;
  localparam int C_EXP_BITS_DEF = 8;
  localparam int C_CNT_BITS_DEF = 5;

  // A nonzero mantissa needs at most this many left shifts to reach MSB=1.
  localparam int C_MAX_SHIFT = C_NUM_BITS_DEF - 1;

endpackage

// File: rtl/quotient_normalizer.sv
// Left-normalizes the raw divider quotient one bit per clock, adjusting the exponent,
// and presents the result to the round/pack stage over a valid/ready handshake.
//
// state | meaning
// IDLE  | ready for a new quotient (IR=1)
// SHIFT | shifting mantissa left until MSB=1 or exponent reaches 0
// HOLD  | result valid (OV=1), held stable until ORDY
module quotient_normalizer
  import qnorm_pkg::*;
#(
  parameter int C_NUM_BITS = C_NUM_BITS_DEF,
  parameter int C_EXP_BITS = C_EXP_BITS_DEF,
  parameter int C_CNT_BITS = C_CNT_BITS_DEF
) (
  input  logic                  CK,
  input  logic                  RN,
  input  logic                  IV,
  output logic                  IR,
  input  logic [C_NUM_BITS-1:0] QIN,
  input  logic [C_EXP_BITS-1:0] EIN,
  output logic                  OV,
  input  logic                  ORDY,
  output logic [C_NUM_BITS-1:0] M,
  output logic [C_EXP_BITS-1:0] EXP,
  output logic [C_CNT_BITS-1:0] SH,
  output logic                  ZF,
  output logic                  UF
);

  qnorm_state_t          r_state;
  logic [C_NUM_BITS-1:0] r_mant;
  logic [C_EXP_BITS-1:0] r_exp;
  logic [C_CNT_BITS-1:0] r_sh;
  logic                  r_zf;
  logic                  r_uf;
  logic                  r_ov;
  logic                  r_ir;

  logic w_msb;
  logic w_exp_zero;

  assign w_msb      = r_mant[C_NUM_BITS-1];
  assign w_exp_zero = (r_exp == '0);

  always_ff @(posedge CK) begin
    if (!RN) begin
      r_state <= IDLE;
      r_mant  <= '0;
      r_exp   <= '0;
      r_sh    <= '0;
      r_zf    <= 1'b0;
      r_uf    <= 1'b0;
      r_ov    <= 1'b0;
      r_ir    <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (IV) begin
            r_mant <= QIN;
            r_exp  <= EIN;
            r_sh   <= '0;
            r_zf   <= 1'b0;
            r_uf   <= 1'b0;
            r_ir   <= 1'b0;
            // Zero quotient skips normalization and reports a clean zero.
            if (QIN == '0) begin
              r_state <= HOLD;
              r_zf    <= 1'b1;
              r_exp   <= '0;
              r_ov    <= 1'b1;
            end else begin
              r_state <= SHIFT;
            end
          end
        end

        SHIFT: begin
          // MSB check has priority so a mantissa normalized exactly at exp==0 is not flagged.
          if (w_msb) begin
            r_state <= HOLD;
            r_ov    <= 1'b1;
          end else if (w_exp_zero) begin
            r_state <= HOLD;
            r_uf    <= 1'b1;
            r_ov    <= 1'b1;
          end else begin
            r_mant <= {r_mant[C_NUM_BITS-2:0], 1'b0};
            r_exp  <= r_exp - C_EXP_BITS'(1);
            r_sh   <= r_sh + C_CNT_BITS'(1);
          end
        end

        HOLD: begin
          if (ORDY) begin
            r_state <= IDLE;
            r_ov    <= 1'b0;
            r_ir    <= 1'b1;
          end
        end

        default: begin
          r_state <= IDLE;
          r_ov    <= 1'b0;
          r_ir    <= 1'b1;
        end
      endcase
    end
  end

  assign IR  = r_ir;
  assign OV  = r_ov;
  assign M   = r_mant;
  assign EXP = r_exp;
  assign SH  = r_sh;
  assign ZF  = r_zf;
  assign UF  = r_uf;

endmodule

// File: tb/tb_quotient_normalizer.sv
// Directed self-checking bench for quotient_normalizer with hand-computed vectors.
module tb_quotient_normalizer;

  logic        CK;
  logic        RN;
  logic        IV;
  logic        IR;
  logic [23:0] QIN;
  logic [7:0]  EIN;
  logic        OV;
  logic        ORDY;
  logic [23:0] M;
  logic [7:0]  EXP;
  logic [4:0]  SH;
  logic        ZF;
  logic        UF;

  int n_err;
  int n_chk;
  int lat;

  quotient_normalizer #(
    .C_NUM_BITS(24),
    .C_EXP_BITS(8),
    .C_CNT_BITS(5)
  ) dut (
    .CK  (CK),
    .RN  (RN),
    .IV  (IV),
    .IR  (IR),
    .QIN (QIN),
    .EIN (EIN),
    .OV  (OV),
    .ORDY(ORDY),
    .M   (M),
    .EXP (EXP),
    .SH  (SH),
    .ZF  (ZF),
    .UF  (UF)
  );

  initial CK = 1'b0;
  always #5 CK = ~CK;

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    assert (obs === exp_v)
    else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Counts edges after the accept edge until OV is seen; bounded.
  task automatic wait_ov(output int n);
    n = 0;
    while (OV !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic accept(input logic [23:0] q, input logic [7:0] e);
    IV  = 1'b1;
    QIN = q;
    EIN = e;
    tick();
    IV  = 1'b0;
  endtask

  task automatic check_result(input string tag, input int exp_lat, input logic [23:0] em,
                              input logic [7:0] ee, input logic [4:0] es,
                              input logic ez, input logic eu);
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_ov"},  32'(OV),  32'd1);
    check({tag, "_m"},   32'(M),   32'(em));
    check({tag, "_exp"}, 32'(EXP), 32'(ee));
    check({tag, "_sh"},  32'(SH),  32'(es));
    check({tag, "_zf"},  32'(ZF),  32'(ez));
    check({tag, "_uf"},  32'(UF),  32'(eu));
    check({tag, "_ir"},  32'(IR),  32'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ov"},  32'(OV),  32'd0);
    check({tag, "_ir"},  32'(IR),  32'd1);
    check({tag, "_m"},   32'(M),   32'd0);
    check({tag, "_exp"}, 32'(EXP), 32'd0);
    check({tag, "_sh"},  32'(SH),  32'd0);
    check({tag, "_zf"},  32'(ZF),  32'd0);
    check({tag, "_uf"},  32'(UF),  32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_err = 0;
    n_chk = 0;
    RN    = 1'b0;
    IV    = 1'b0;
    QIN   = '0;
    EIN   = '0;
    ORDY  = 1'b1;
    tick();
    tick();
    check_reset_vals("reset");
    RN = 1'b1;

    // MSB already set: best case latency 1.
    accept(24'h800000, 8'h7F);
    check("best_accept_ov", 32'(OV), 32'd0);
    wait_ov(lat);
    check_result("best", 1, 24'h800000, 8'h7F, 5'd0, 1'b0, 1'b0);
    tick();
    check("best_consume_ov", 32'(OV), 32'd0);
    check("best_consume_ir", 32'(IR), 32'd1);

    // Worst case: 23 shifts.
    accept(24'h000001, 8'h7F);
    wait_ov(lat);
    check_result("worst", 24, 24'h800000, 8'h68, 5'd23, 1'b0, 1'b0);
    tick();

    // Zero quotient: OV right after accept.
    accept(24'h000000, 8'h55);
    wait_ov(lat);
    check_result("zero", 0, 24'h000000, 8'h00, 5'd0, 1'b1, 1'b0);
    tick();
    check("zero_consume_ir", 32'(IR), 32'd1);

    // Underflow: lz=11 but exponent only allows 3 shifts.
    accept(24'h001000, 8'h03);
    wait_ov(lat);
    check_result("uflow", 4, 24'h008000, 8'h00, 5'd3, 1'b0, 1'b1);
    tick();

    // Exponent already zero with MSB clear: underflow with no shift.
    accept(24'h400000, 8'h00);
    wait_ov(lat);
    check_result("exp0", 1, 24'h400000, 8'h00, 5'd0, 1'b0, 1'b1);
    tick();

    // Exponent hits zero exactly as MSB reaches 1: normalized, not underflow.
    accept(24'h100000, 8'h03);
    wait_ov(lat);
    check_result("exact", 4, 24'h800000, 8'h00, 5'd3, 1'b0, 1'b0);
    tick();

    // Backpressure: result held stable, IV pulse ignored.
    ORDY = 1'b0;
    accept(24'h400000, 8'h10);
    wait_ov(lat);
    check_result("bp", 2, 24'h800000, 8'h0F, 5'd1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        IV  = 1'b1;
        QIN = 24'h123456;
        EIN = 8'hAA;
      end else begin
        IV = 1'b0;
      end
      tick();
      check("bp_hold_ov",  32'(OV),  32'd1);
      check("bp_hold_ir",  32'(IR),  32'd0);
      check("bp_hold_m",   32'(M),   32'h800000);
      check("bp_hold_exp", 32'(EXP), 32'h0F);
      check("bp_hold_sh",  32'(SH),  32'd1);
    end
    IV   = 1'b0;
    ORDY = 1'b1;
    tick();
    check("bp_release_ov", 32'(OV), 32'd0);
    check("bp_release_ir", 32'(IR), 32'd1);

    // Reset in the middle of shifting discards the pending result.
    accept(24'h000004, 8'h7F);
    for (int i = 0; i < 4; i++) tick();
    check("mid_shift_ov", 32'(OV), 32'd0);
    RN = 1'b0;
    tick();
    check_reset_vals("mid_reset");
    RN = 1'b1;
    accept(24'h800000, 8'h40);
    wait_ov(lat);
    check_result("after_reset", 1, 24'h800000, 8'h40, 5'd0, 1'b0, 1'b0);
    tick();
    check("after_reset_ir", 32'(IR), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/quotient_normalizer.md
# quotient_normalizer

Downstream stage of the 24-bit divider: captures the raw quotient, plus the exponent computed alongside it, and left-normalizes the mantissa until its MSB is 1. Normalization shifts one bit per clock and decrements the exponent on each shift. Stops early on a zero quotient or on exponent underflow. Hands the result to the rounding/pack stage over a valid/ready handshake.

## Interface
Parameters:
- C_NUM_BITS, 24, mantissa/quotient width
- C_EXP_BITS, 8, exponent width (unsigned, biased)
- C_CNT_BITS, 5, width of shift-count output; must satisfy 2^C_CNT_BITS > C_NUM_BITS - 1

Ports:
- CK  in  1  clock; single clock domain
- RN  in  1  reset; synchronous, active-low. Sampled on rising CK only.
- IV  in  1  input valid (quotient latched valid from divider)
- IR  out  1  input ready
- QIN  in  C_NUM_BITS  raw quotient
- EIN  in  C_EXP_BITS  unadjusted biased exponent
- OV  out  1  output valid
- ORDY  in  1  output ready from downstream
- M  out  C_NUM_BITS  normalized mantissa
- EXP  out  C_EXP_BITS  adjusted exponent
- SH  out  C_CNT_BITS  number of left shifts applied
- ZF  out  1  result is zero
- UF  out  1  exponent underflow stopped normalization

## Operation
- States: IDLE, SHIFT, HOLD.
- IDLE:
  - IR=1, OV=0.
  - On IV=1: load mant←QIN, exp←EIN, SH←0, ZF←0, UF←0.
  - If QIN==0, go to HOLD with ZF=1, M=0, EXP=0. Otherwise go to SHIFT.
- SHIFT, evaluated each cycle in priority order:
  - mant[MSB]==1: go to HOLD; no shift this cycle.
  - exp==0: set UF=1, go to HOLD; mantissa is left denormal.
  - Otherwise: mant←mant<<1 (zero fill), exp←exp-1, SH←SH+1; stay in SHIFT.
- HOLD:
  - OV=1. M, EXP, SH, ZF and UF are stable and unchanged while OV=1 and ORDY=0.
  - On ORDY=1, go to IDLE.
- Arithmetic:
  - exp never wraps. The decrement happens only when exp≠0.
  - SH saturates naturally at C_NUM_BITS-1, because a nonzero mantissa reaches MSB=1 within C_NUM_BITS-1 shifts.
- IR is asserted only in IDLE. A new operand is never accepted in the same cycle an output is consumed, so there is no bypass.
- IV while not in IDLE is ignored. The upstream holds IV until it sees IR.

## Timing
- Reset: RN=0 at a rising CK forces IDLE, with OV=0, IR=1, M=0, EXP=0, SH=0, ZF=0, UF=0. This applies in any state, including mid-SHIFT or during HOLD; the pending result is discarded. IR reads 1 in the cycle after the reset edge.
- Accept edge is t0 (IDLE, IV=1). With lz = leading zeros of QIN:
  - Nonzero QIN, no underflow: OV rises after edge t0+lz+1.
  - Best case (MSB already set): OV rises after t0+1.
  - Worst case (lz=C_NUM_BITS-1): OV rises after t0+C_NUM_BITS.
  - Zero QIN: OV rises after t0, one cycle earlier than the best nonzero case.
  - Underflow: OV rises after t0+EIN+1 when EIN<lz.
- Output consumed at edge t1 (HOLD, ORDY=1): OV=0 and IR=1 from t1. The earliest next accept is edge t1+1.
- Throughput: one result per lz+3 cycles minimum, with ORDY held high.
- All outputs are registered; no combinational path from IV or ORDY to any output.

## Structure
- Package `qnorm_pkg`:
  - state enum `qnorm_state_t` {IDLE, SHIFT, HOLD}
  - default width constants C_NUM_BITS=24, C_EXP_BITS=8
  - localparam for the maximum shift count
- Single module; FSM and datapath together.
- No sub-module: the shifter is a one-bit shift register with load, simpler inline than a reused universal shift register.

## Test plan
- QIN=0x800000, EIN=0x7F, ORDY=1 → OV after t0+1; M=0x800000, EXP=0x7F, SH=0, ZF=0, UF=0.
- QIN=0x000001, EIN=0x7F → OV after t0+24; M=0x800000, EXP=0x68, SH=23.
- QIN=0x000000, EIN=0x55 → OV after t0; ZF=1, M=0, EXP=0, SH=0.
- QIN=0x001000 (lz=11), EIN=0x03 → UF=1, EXP=0, SH=3, M=0x008000, OV after t0+4.
- Backpressure: QIN=0x400000, EIN=0x10, ORDY=0 for 10 cycles → OV stays 1, with M=0x800000, EXP=0x0F and SH=1 stable throughout; IR=0; a pulse on IV is ignored; ORDY=1 → IR=1 next cycle.
- Reset mid-SHIFT: QIN=0x000004, then RN=0 at t0+5 → next cycle all outputs at reset values, IR=1. A fresh QIN=0x800000 then completes normally.
